mem_master: RTL and testbench

- Bus-master sequencer that drives the control and address side of the synchronous block-RAM memory.
- Signals driven: d_read, d_write, d_push, i_read, i_push, d_addr, i_addr, and the shared 16-bit d_bus.
- Accepts instruction fetches from the fetch stage and loads/stores from the execute stage, each on a req/ack handshake.
- Arbitrates fairly between the two requesters and sequences each access (read, then push-capture; or write) with fixed latency.

---
 rtl/mem_master.sv | 219 +++++++++++++++++++++
 tb/tb_mem_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// mem_master: bus-master sequencer for the synchronous block RAM.
// Arbitrates between instruction fetch and load/store requesters and
// sequences each access (read + push-capture, or write) with fixed latency.
// Optional statistics counters are built when MEM_MASTER_STATS_EN is defined.
module mem_master #(
    parameter int MEM_SIZE = 512,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_ack,
    output logic [DW-1:0] fetch_data,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_ack,
    output logic [DW-1:0] ls_rdata,
    output logic          fault,
    output logic          busy,
    output logic          d_read,
    output logic          d_write,
    output logic          d_push,
    output logic          i_read,
    output logic          i_push,
    output logic [AW-1:0] d_addr,
    output logic [AW-1:0] i_addr,
    inout  wire  [DW-1:0] d_bus,
    output logic [15:0]   fetch_count,
    output logic [15:0]   load_count,
    output logic [15:0]   store_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_RD   = 3'd1,
        I_PUSH = 3'd2,
        D_RD   = 3'd3,
        D_PUSH = 3'd4,
        D_WR   = 3'd5,
        ACK_F  = 3'd6,
        ACK_D  = 3'd7
    } state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEM_SIZE);

    state_t        state_q, state_d;
    grant_t        last_grant_q;
    logic          fault_q;
    logic [DW-1:0] wdata_q;
    logic          bus_oe;
    logic          grant_f, grant_d;
    logic          f_oob, d_oob;

    // Arbitration: a lone request wins; on contention the side not granted last time wins.
    assign f_oob   = (fetch_addr >= MEM_LIMIT);
    assign d_oob   = (ls_addr >= MEM_LIMIT);
    assign grant_f = (state_q == IDLE) && fetch_req &&
                     (!ls_req || (last_grant_q == GRANT_DATA));
    assign grant_d = (state_q == IDLE) && ls_req && !grant_f;

    // The block only drives the shared bus while a store is being written.
    assign d_bus = bus_oe ? wdata_q : {DW{1'bz}};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; out-of-range accesses skip straight to their ack state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_f) begin
                    state_d = f_oob ? ACK_F : I_RD;
                end else if (grant_d) begin
                    if (d_oob) begin
                        state_d = ACK_D;
                    end else begin
                        state_d = ls_we ? D_WR : D_RD;
                    end
                end
            end
            I_RD:    state_d = I_PUSH;
            I_PUSH:  state_d = ACK_F;
            D_RD:    state_d = D_PUSH;
            D_PUSH:  state_d = ACK_D;
            D_WR:    state_d = ACK_D;
            ACK_F:   state_d = IDLE;
            ACK_D:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode: one memory control per state, acks in the ACK states.
    always_comb begin
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_push    = 1'b0;
        i_read    = 1'b0;
        i_push    = 1'b0;
        fetch_ack = 1'b0;
        ls_ack    = 1'b0;
        bus_oe    = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            I_RD:    i_read = 1'b1;
            I_PUSH:  i_push = 1'b1;
            D_RD:    d_read = 1'b1;
            D_PUSH:  d_push = 1'b1;
            D_WR: begin
                d_write = 1'b1;
                bus_oe  = 1'b1;
            end
            ACK_F:   fetch_ack = 1'b1;
            ACK_D:   ls_ack    = 1'b1;
            default: ;
        endcase
        fault = fault_q && ((state_q == ACK_F) || (state_q == ACK_D));
    end

    // Latch address, store data, fault flag and arbitration history on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_addr       <= '0;
            d_addr       <= '0;
            wdata_q      <= '0;
            fault_q      <= 1'b0;
            last_grant_q <= GRANT_DATA;
        end else if (grant_f) begin
            i_addr       <= fetch_addr;
            fault_q      <= f_oob;
            last_grant_q <= GRANT_FETCH;
        end else if (grant_d) begin
            d_addr       <= ls_addr;
            wdata_q      <= ls_wdata;
            fault_q      <= d_oob;
            last_grant_q <= GRANT_DATA;
        end
    end

    // Capture read data off the bus in the push cycles; faulted reads return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_data <= '0;
            ls_rdata   <= '0;
        end else begin
            if (state_q == I_PUSH) begin
                fetch_data <= d_bus;
            end else if (grant_f && f_oob) begin
                fetch_data <= '0;
            end
            if (state_q == D_PUSH) begin
                ls_rdata <= d_bus;
            end else if (grant_d && d_oob && !ls_we) begin
                ls_rdata <= '0;
            end
        end
    end

`ifdef MEM_MASTER_STATS_EN
    logic        we_q;
    logic [15:0] fetch_cnt, load_cnt, store_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Remember whether the granted data access is a store, for the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q <= 1'b0;
        end else if (grant_d) begin
            we_q <= ls_we;
        end
    end

    // Saturating per-kind counters bumped on every ack, faulted ones included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (state_q == ACK_F) begin
                fetch_cnt <= sat_inc(fetch_cnt);
            end
            if ((state_q == ACK_D) && !we_q) begin
                load_cnt <= sat_inc(load_cnt);
            end
            if ((state_q == ACK_D) && we_q) begin
                store_cnt <= sat_inc(store_cnt);
            end
        end
    end

    assign fetch_count = fetch_cnt;
    assign load_count  = load_cnt;
    assign store_count = store_cnt;
`else
    assign fetch_count = '0;
    assign load_count  = '0;
    assign store_count = '0;
`endif

endmodule

// File: tb/tb_mem_master.sv
// Testbench for mem_master: behavioural block RAM on the bus, transaction-level
// expectations from a word-array reference, directed and random accesses.
module tb_mem_master;

    localparam int MEM_SIZE = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [15:0] ls_wdata = '0;
    logic        ls_ack;
    logic [15:0] ls_rdata;
    logic        fault, busy;
    logic        d_read, d_write, d_push, i_read, i_push;
    logic [15:0] d_addr, i_addr;
    wire  [15:0] d_bus;
    logic [15:0] fetch_count, load_count, store_count;

    mem_master #(.MEM_SIZE(MEM_SIZE), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .fault(fault), .busy(busy),
        .d_read(d_read), .d_write(d_write), .d_push(d_push),
        .i_read(i_read), .i_push(i_push),
        .d_addr(d_addr), .i_addr(i_addr), .d_bus(d_bus),
        .fetch_count(fetch_count), .load_count(load_count), .store_count(store_count)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read registers data, push drives it onto the bus, write samples the bus.
    logic [15:0] ram [0:MEM_SIZE-1];
    logic [15:0] rd_lat = '0;
    logic        fill_en = 1'b0;
    logic [8:0]  fill_idx = '0;
    logic [15:0] fill_val = '0;

    always @(posedge clk) begin
        if (fill_en) ram[fill_idx] <= fill_val;
        else if (d_write) ram[d_addr[8:0]] <= d_bus;
        if (d_read) rd_lat <= ram[d_addr[8:0]];
        else if (i_read) rd_lat <= ram[i_addr[8:0]];
    end
    assign d_bus = (d_push || i_push) ? rd_lat : 16'hzzzz;

    // Reference contents and expected statistics.
    logic [15:0] exp_mem [0:MEM_SIZE-1];
    int cnt_f = 0, cnt_l = 0, cnt_s = 0;
    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus-level invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ctl_onehot", 32'($countones({d_read, d_write, d_push, i_read, i_push}) <= 1), 1);
            if (!d_write && !d_push && !i_push)
                chk("bus_released", 32'((d_bus === 16'hzzzz) || (d_bus === 16'h0000)), 1);
            chk("fault_wo_ack", 32'(fault && !fetch_ack && !ls_ack), 0);
            if (d_read || d_write || d_push) chk("d_addr_range", 32'(d_addr >= 16'(MEM_SIZE)), 0);
            if (i_read || i_push) chk("i_addr_range", 32'(i_addr >= 16'(MEM_SIZE)), 0);
        end
    end

    // Expected control vector {d_read,d_write,d_push,i_read,i_push} in cycle n after sampling.
    function automatic logic [4:0] exp_ctl(input bit is_f, input bit we, input bit flt, input int n);
        if (flt) return 5'b00000;
        if (is_f) return (n == 1) ? 5'b00010 : (n == 2) ? 5'b00001 : 5'b00000;
        if (we) return (n == 1) ? 5'b01000 : 5'b00000;
        return (n == 1) ? 5'b10000 : (n == 2) ? 5'b00100 : 5'b00000;
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One complete access from an idle master, checking sequence, latency and result.
    task automatic do_xact(input bit is_f, input bit we, input logic [15:0] addr, input logic [15:0] wd);
        bit          flt, done;
        int          lat, n;
        logic [15:0] exp_d, held;
        flt = (addr >= 16'(MEM_SIZE));
        lat = flt ? 1 : (!is_f && we) ? 2 : 3;
        exp_d = flt ? 16'h0000 : exp_mem[addr[8:0]];
        @(negedge clk);
        if (is_f) begin
            fetch_req = 1'b1; fetch_addr = addr;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        end
        n = 0; done = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
            chk("ctl_seq", {27'b0, d_read, d_write, d_push, i_read, i_push}, 32'(exp_ctl(is_f, we, flt, n)));
            chk("busy", 32'(busy), 1);
            chk("other_ack", 32'(is_f ? ls_ack : fetch_ack), 0);
            if (!is_f && we && !flt && n == 1) chk("wr_bus", 32'(d_bus), 32'(wd));
            if (is_f ? fetch_ack : ls_ack) done = 1;
        end
        chk("latency", n, lat);
        chk("fault", 32'(fault), 32'(flt));
        chk("addr_latch", 32'(is_f ? i_addr : d_addr), 32'(addr));
        if (is_f) chk("fetch_data", 32'(fetch_data), 32'(exp_d));
        else if (!we) chk("ls_rdata", 32'(ls_rdata), 32'(exp_d));
        if (!is_f && we && !flt) exp_mem[addr[8:0]] = wd;
        if (is_f) cnt_f++; else if (we) cnt_s++; else cnt_l++;
        held = is_f ? fetch_data : ls_rdata;
        fetch_req = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", 32'(is_f ? fetch_ack : ls_ack), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("data_hold", 32'(is_f ? fetch_data : ls_rdata), 32'(held));
    endtask

    task automatic chk_stats(input string tag);
`ifdef MEM_MASTER_STATS_EN
        chk({tag, "_fcnt"}, 32'(fetch_count), sat(cnt_f));
        chk({tag, "_lcnt"}, 32'(load_count), sat(cnt_l));
        chk({tag, "_scnt"}, 32'(store_count), sat(cnt_s));
`else
        chk({tag, "_fcnt"}, 32'(fetch_count), 0);
        chk({tag, "_lcnt"}, 32'(load_count), 0);
        chk({tag, "_scnt"}, 32'(store_count), 0);
`endif
    endtask

    initial begin
        int order [$];
        int n;
        // Fill memory while reset is held; check reset state along the way.
        for (int i = 0; i < MEM_SIZE; i++) begin
            @(negedge clk);
            fill_en  = 1'b1;
            fill_idx = 9'(i);
            fill_val = (i == 16) ? 16'hBF01 : 16'($urandom);
            exp_mem[i] = fill_val;
            if (i == 3) begin
                chk("rst_fetch_ack", 32'(fetch_ack), 0);
                chk("rst_ls_ack", 32'(ls_ack), 0);
                chk("rst_fault", 32'(fault), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_fetch_data", 32'(fetch_data), 0);
                chk("rst_ls_rdata", 32'(ls_rdata), 0);
                chk("rst_addrs", {d_addr, i_addr}, 0);
                chk("rst_ctl", {27'b0, d_read, d_write, d_push, i_read, i_push}, 0);
                chk_stats("rst");
            end
        end
        @(negedge clk);
        fill_en = 1'b0;
        rst = 1'b0;

        // Directed: fetch, store/load round trip, faults, alias check after faulted store.
        do_xact(1, 0, 16'd16, 16'h0000);
        do_xact(0, 1, 16'd300, 16'hA5A5);
        do_xact(0, 0, 16'd300, 16'h0000);
        do_xact(0, 0, 16'd512, 16'h0000);
        do_xact(0, 1, 16'd600, 16'h1234);
        do_xact(0, 0, 16'd88, 16'h0000);
        do_xact(1, 0, 16'd700, 16'h0000);
        chk_stats("directed");

        // Contention from reset: both requests held, grants alternate starting with fetch.
        @(negedge clk);
        rst = 1'b1;
        fetch_req = 1'b1; fetch_addr = 16'd16;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'd300;
        cnt_f = 0; cnt_l = 0; cnt_s = 0;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (order.size() < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (fetch_ack) begin
                order.push_back(0); cnt_f++;
                chk("cont_fdata", 32'(fetch_data), 32'(exp_mem[16]));
            end
            if (ls_ack) begin
                order.push_back(1); cnt_l++;
                chk("cont_ldata", 32'(ls_rdata), 32'(exp_mem[300]));
            end
        end
        fetch_req = 1'b0; ls_req = 1'b0;
        chk("cont_count", order.size(), 4);
        foreach (order[i]) chk("cont_order", order[i], i % 2);
        @(negedge clk);
        chk("cont_idle", 32'(busy), 0);
        chk_stats("contention");

        // Reset during D_PUSH: everything clears at once, then the load is re-run.
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'd300;
        n = 0;
        while (!d_push && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_push_seen", 32'(d_push), 1);
        #1 rst = 1'b1;
        ls_req = 1'b0;
        #1;
        chk("mid_ctl", {27'b0, d_read, d_write, d_push, i_read, i_push}, 0);
        chk("mid_acks", {29'b0, fetch_ack, ls_ack, fault}, 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_data", {fetch_data, ls_rdata}, 0);
        chk("mid_addrs", {d_addr, i_addr}, 0);
        chk("mid_bus", 32'((d_bus === 16'hzzzz) || (d_bus === 16'h0000)), 1);
        cnt_f = 0; cnt_l = 0; cnt_s = 0;
        @(negedge clk);
        rst = 1'b0;
        do_xact(0, 0, 16'd300, 16'h0000);

        // Random accesses; stores biased to a small window so loads hit them.
        for (int k = 0; k < 60; k++) begin
            int          kind;
            logic [15:0] a;
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(MEM_SIZE, 65535));
            else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 31));
            else a = 16'($urandom_range(0, MEM_SIZE - 1));
            do_xact(kind == 0, kind == 2, a, 16'($urandom));
        end
        chk_stats("random");

`ifdef MEM_MASTER_STATS_EN
        // Counter saturation.
        @(negedge clk);
        force dut.fetch_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.fetch_cnt;
        cnt_f = 65534;
        do_xact(1, 0, 16'd5, 16'h0000);
        do_xact(1, 0, 16'd6, 16'h0000);
        chk("sat_fcnt", 32'(fetch_count), 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
